// File: rtl/rf_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : rf_copy_engine
// Description : Command-driven block mover for a 2-read/1-write register
//               file. Accepts one command at a time (copy, add, clear),
//               streams one word per cycle through the register file ports
//               with memmove-style direction selection, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_copy_engine #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  // command channel
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [1:0]         i_cmd_op,
  input  logic [BW_ADDR-1:0] i_cmd_src,
  input  logic [BW_ADDR-1:0] i_cmd_dst,
  input  logic [BW_ADDR:0]   i_cmd_len,
  // status
  output logic               o_busy,
  output logic               o_done,
  // register file ports
  output logic [BW_ADDR-1:0] o_rf_rd_addr0,
  output logic [BW_ADDR-1:0] o_rf_rd_addr1,
  input  logic [BW_DATA-1:0] i_rf_rd_data0,
  input  logic [BW_DATA-1:0] i_rf_rd_data1,
  output logic [BW_DATA-1:0] o_rf_wr_data,
  output logic [BW_ADDR-1:0] o_rf_wr_addr,
  output logic               o_rf_wr_en
);

  // Operation encodings; 2'b11 falls through to copy.
  localparam logic [1:0] c_OP_ADD   = 2'b01;
  localparam logic [1:0] c_OP_CLEAR = 2'b10;

  localparam logic [BW_ADDR:0] c_LEN_ZERO = '0;
  localparam logic [BW_ADDR:0] c_LEN_ONE  = {{BW_ADDR{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched command
  logic [1:0]         r_op;
  logic [BW_ADDR-1:0] r_src;
  logic [BW_ADDR-1:0] r_dst;
  logic               r_desc;
  // Current word index and words still to be written (including current)
  logic [BW_ADDR-1:0] r_idx;
  logic [BW_ADDR:0]   r_remain;

  logic               w_accept;
  logic               w_run;
  logic               w_last;
  logic [BW_ADDR-1:0] w_diff;
  logic               w_desc;
  logic [BW_ADDR-1:0] w_len_m1;
  logic [BW_ADDR-1:0] w_src_addr;
  logic [BW_ADDR-1:0] w_dst_addr;

  assign w_accept = i_cmd_valid && (r_state == ST_IDLE);
  assign w_run    = (r_state == ST_RUN);
  assign w_last   = (r_remain == c_LEN_ONE);

  // Distance from source to destination, modulo the register file depth.
  // If the destination starts inside the source block, walking downwards
  // reads each source word before it can be overwritten.
  assign w_diff   = i_cmd_dst - i_cmd_src;
  assign w_desc   = (w_diff != '0) && ({1'b0, w_diff} < i_cmd_len);
  // Low bits of len-1; for a full-depth length this wraps to the top index.
  assign w_len_m1 = i_cmd_len[BW_ADDR-1:0] - 1'b1;

  assign w_src_addr = r_src + r_idx;
  assign w_dst_addr = r_dst + r_idx;

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake/status outputs
  always_comb begin
    w_state_nxt = r_state;
    o_cmd_ready = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_rf_wr_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          w_state_nxt = (i_cmd_len == c_LEN_ZERO) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        o_busy     = 1'b1;
        o_rf_wr_en = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command latch at acceptance, index/count stepping while running
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_op     <= 2'b00;
      r_src    <= '0;
      r_dst    <= '0;
      r_desc   <= 1'b0;
      r_idx    <= '0;
      r_remain <= '0;
    end else if (w_accept) begin
      r_op     <= i_cmd_op;
      r_src    <= i_cmd_src;
      r_dst    <= i_cmd_dst;
      r_desc   <= w_desc;
      r_idx    <= w_desc ? w_len_m1 : '0;
      r_remain <= i_cmd_len;
    end else if (w_run) begin
      r_remain <= r_remain - c_LEN_ONE;
      r_idx    <= r_desc ? (r_idx - 1'b1) : (r_idx + 1'b1);
    end
  end

  // Addresses depend only on registers; held at zero outside RUN
  always_comb begin
    o_rf_rd_addr0 = '0;
    o_rf_rd_addr1 = '0;
    o_rf_wr_addr  = '0;
    if (w_run) begin
      o_rf_rd_addr0 = w_src_addr;
      o_rf_rd_addr1 = w_dst_addr;
      o_rf_wr_addr  = w_dst_addr;
    end
  end

  // Write data combines same-cycle read data according to the latched op
  always_comb begin
    o_rf_wr_data = '0;
    if (w_run) begin
      case (r_op)
        c_OP_ADD:   o_rf_wr_data = i_rf_rd_data0 + i_rf_rd_data1;
        c_OP_CLEAR: o_rf_wr_data = '0;
        default:    o_rf_wr_data = i_rf_rd_data0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/rf_copy_engine.md
# rf_copy_engine

Command-driven initiator that drives the read and write ports of the team's 2-read/1-write register file (asynchronous read, synchronous write) to move or combine blocks of registers. It accepts one block command at a time over a valid/ready handshake. It processes one word per cycle and pulses done on completion. It sits between a control sequencer and a `regfile` instance and owns all regfile ports while busy.

## Interface
- `BW_DATA`, 32, register word width
- `BW_ADDR`, 5, register address width; regfile depth is 2**BW_ADDR
- `i_clk` input 1: single clock, rising edge
- `i_rstn` input 1: asynchronous active-low reset
- `i_cmd_valid` input 1: command present
- `o_cmd_ready` output 1: engine idle and able to accept a command
- `i_cmd_op` input 2: 00 copy, 01 add, 10 clear, 11 treated as copy
- `i_cmd_src` input BW_ADDR: source base address
- `i_cmd_dst` input BW_ADDR: destination base address
- `i_cmd_len` input BW_ADDR+1: word count, 0..2**BW_ADDR
- `o_busy` output 1: command in progress (RUN or DONE)
- `o_done` output 1: one-cycle completion pulse
- `o_rf_rd_addr0` output BW_ADDR: source read address
- `o_rf_rd_addr1` output BW_ADDR: destination read address (add operand)
- `i_rf_rd_data0` input BW_DATA: regfile data for rd_addr0, same cycle
- `i_rf_rd_data1` input BW_DATA: regfile data for rd_addr1, same cycle
- `o_rf_wr_data` output BW_DATA: write data
- `o_rf_wr_addr` output BW_ADDR: write address
- `o_rf_wr_en` output 1: write strobe

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: `o_cmd_ready`=1. On `i_cmd_valid && o_cmd_ready` at a rising edge, latch op, src, dst and len.
  - len==0: go to DONE.
  - Otherwise: go to RUN.
- Direction is decided at accept: descending if ((dst − src) mod 2**BW_ADDR) is nonzero and less than len; otherwise ascending. This gives memmove semantics for overlapping ranges.
- Index i runs 0..len−1 when ascending and len−1..0 when descending. It advances once per RUN cycle.
- Addresses in RUN:
  - `o_rf_rd_addr0` = src+i
  - `o_rf_rd_addr1` = dst+i
  - `o_rf_wr_addr` = dst+i
  - All address sums wrap modulo 2**BW_ADDR.
- Write data in RUN:
  - copy: `i_rf_rd_data0`
  - add: `i_rf_rd_data0 + i_rf_rd_data1`, truncated to BW_DATA with carry discarded
  - clear: 0
- `o_rf_wr_en`=1 in every RUN cycle and 0 otherwise.
- RUN → DONE after the cycle that writes the last index.
- DONE: `o_done`=1 and `o_cmd_ready`=0 for exactly one cycle, then go to IDLE.
- `o_busy`=1 in RUN and DONE.
- src==dst: copy rewrites the same values; add doubles each word.
- Full length (2**BW_ADDR) with any src/dst: every register is written exactly once.

## Timing
- Reset values:
  - state IDLE, `o_cmd_ready`=1
  - `o_busy`=0, `o_done`=0, `o_rf_wr_en`=0
  - all address and data outputs 0
- Write outputs are combinational from registered state/index and same-cycle regfile read data. Address outputs come only from registers, so there is no combinational loop.
- Command accepted at edge k:
  - Writes occur at edges k+1..k+len.
  - `o_done` is high in the cycle after the last write.
  - Next command can be accepted at edge k+len+2. For len==0, `o_done` is high in cycle k+1.
- Commands presented while `o_cmd_ready`=0 are ignored, not queued. `i_cmd_*` are sampled only at acceptance.
- Reset asserted mid-RUN:
  - `o_rf_wr_en` drops immediately (asynchronously) and the engine returns to IDLE.
  - Already-written words remain.
  - No `o_done` pulse is generated for the aborted command.

## Test plan
- Reset then idle: rstn low → all outputs at reset values, `o_cmd_ready`=1; release with no command → no write strobes for 20 cycles.
- Copy, no overlap: preload r[i]=0x100+i; copy src=0, dst=16, len=8 → 8 consecutive writes, r16..r23=0x100..0x107, `o_done` at accept+9, r0..r7 unchanged.
- Overlapping copy, both directions:
  - src=2, dst=4, len=6 runs descending → r4..r9 = original r2..r7.
  - src=4, dst=2, len=6 runs ascending → r2..r7 = original r4..r9.
- Add with wrap:
  - r0=0xFFFFFFFF, r31=0x2; add src=0, dst=31, len=2 → r31=0x00000001, r0=r1+r0 (dst address wraps to 0).
  - Carry is dropped.
- Clear and len==0:
  - clear dst=0, len=32 → all 32 registers zero, exactly 32 strobes.
  - len=0 → no strobe, `o_done` in cycle after accept.
- Reset mid-operation and back-pressure:
  - Copy len=10; `i_cmd_valid` held with a different command during RUN → ignored.
  - rstn low after 4 writes → exactly 4 destination words updated, no `o_done`, next command accepted normally.
